// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester-to-register-file write port bundle
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          hold;
    logic [NUM_REQ-1:0]            grant;
    logic                          write_enable;
    logic [ADDR_WIDTH-1:0]         write_reg;
    logic [DATA_WIDTH-1:0]         write_data;
    modport master (
        output req, req_addr, req_data, hold,
        input  grant, write_enable, write_reg, write_data
    );
    modport slave (
        input  req, req_addr, req_data, hold,
        output grant, write_enable, write_reg, write_data
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter sharing the register file write port
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic                    clock,
    input logic                    reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [PW:0] N = (PW+1)'(NUM_REQ);
    logic [PW-1:0]         ptr, win, idx, ptr_nxt;
    logic [PW:0]           sum;
    logic [NUM_REQ-1:0]    mask, elig, win_oh;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    // scan from the far end so the index nearest ptr is written last and wins
    always_comb begin
        elig = bus.req & ~mask;
        win  = '0;
        sum  = '0;
        idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            idx = PW'(sum >= N ? sum - N : sum);
            win = elig[idx] ? idx : win;
        end
    end
    assign win_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
    assign win_addr = bus.req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_data = bus.req_data[win*DATA_WIDTH +: DATA_WIDTH];
    assign ptr_nxt  = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.grant        <= '0;
            bus.write_enable <= 1'b0;
            bus.write_reg    <= '0;
            bus.write_data   <= '0;
            ptr              <= '0;
            mask             <= '0;
        end else if (bus.hold || elig == '0) begin
            bus.grant        <= '0;
            bus.write_enable <= 1'b0;
            mask             <= '0;
        end else begin
            bus.grant        <= win_oh;
            bus.write_enable <= win_addr != '0;
            bus.write_reg    <= win_addr;
            bus.write_data   <= win_data;
            ptr              <= ptr_nxt;
            mask             <= win_oh;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of grant order, masking, r0, hold and reset
module tb_regfile_write_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    regfile_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
    regfile_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );
    always #5 clock = ~clock;
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    task automatic init_slices();
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i*5 +: 5]   = 5'(i + 1);
            bus.req_data[i*32 +: 32] = 32'hA0 + i;
        end
    endtask
    task automatic pulse_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask
    task automatic test_reset();
        init_slices();
        bus.hold = 1'b0;
        bus.req = 4'b1111;
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if (bus.grant !== 4'b0 || bus.write_enable !== 1'b0 || bus.write_reg !== 5'd0 || bus.write_data !== 32'd0) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d: got g=%b we=%b reg=%0d data=%h want all zero", c, bus.grant, bus.write_enable, bus.write_reg, bus.write_data);
            end
        end
        reset = 1'b1;
        step();
        total++;
        if (bus.grant !== 4'b0001 || bus.write_reg !== 5'd1 || bus.write_data !== 32'hA0 || bus.write_enable !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_grant: got g=%b reg=%0d data=%h we=%b want g=0001 reg=1 data=a0 we=1", bus.grant, bus.write_reg, bus.write_data, bus.write_enable);
        end
    endtask
    task automatic test_round_robin();
        logic [3:0] eg;
        init_slices();
        bus.req = 4'b1111;
        pulse_reset();
        for (int c = 0; c < 5; c++) begin
            step();
            eg = 4'b0001 << (c % 4);
            total++;
            if (bus.grant !== eg || bus.write_reg !== 5'((c % 4) + 1) || bus.write_data !== 32'hA0 + (c % 4) || bus.write_enable !== 1'b1) begin
                bad++;
                $display("FAIL round_robin cycle %0d: got g=%b reg=%0d data=%h we=%b want g=%b reg=%0d data=%h we=1", c, bus.grant, bus.write_reg, bus.write_data, bus.write_enable, eg, (c % 4) + 1, 32'hA0 + (c % 4));
            end
        end
        bus.req = 4'b0000;
        step();
        total++;
        if (bus.grant !== 4'b0 || bus.write_enable !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_grant: got g=%b we=%b want 0000 0", bus.grant, bus.write_enable);
        end
    endtask
    task automatic test_mask();
        logic [3:0] eg;
        init_slices();
        bus.req = 4'b0000;
        pulse_reset();
        bus.req = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            step();
            eg = (c % 2 == 0) ? 4'b0100 : 4'b0000;
            total++;
            if (bus.grant !== eg || bus.write_enable !== eg[2]) begin
                bad++;
                $display("FAIL mask cycle %0d: got g=%b we=%b want g=%b we=%b", c, bus.grant, bus.write_enable, eg, eg[2]);
            end
        end
        bus.req = 4'b0000;
    endtask
    task automatic test_r0_suppress();
        init_slices();
        bus.req = 4'b0000;
        pulse_reset();
        bus.req_addr[5 +: 5] = 5'd0;
        bus.req_data[32 +: 32] = 32'hDEADBEEF;
        bus.req = 4'b0010;
        step();
        total++;
        if (bus.grant !== 4'b0010 || bus.write_enable !== 1'b0 || bus.write_reg !== 5'd0 || bus.write_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL r0_suppress: got g=%b we=%b reg=%0d data=%h want g=0010 we=0 reg=0 data=deadbeef", bus.grant, bus.write_enable, bus.write_reg, bus.write_data);
        end
        bus.req = 4'b0000;
        step();
        total++;
        if (bus.grant !== 4'b0 || bus.write_enable !== 1'b0 || bus.write_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL r0_idle_hold: got g=%b we=%b data=%h want g=0000 we=0 data=deadbeef", bus.grant, bus.write_enable, bus.write_data);
        end
    endtask
    task automatic test_hold();
        init_slices();
        bus.req = 4'b0000;
        pulse_reset();
        bus.req = 4'b0010;
        step();
        total++;
        if (bus.grant !== 4'b0010 || bus.write_reg !== 5'd2) begin
            bad++;
            $display("FAIL hold_setup: got g=%b reg=%0d want g=0010 reg=2", bus.grant, bus.write_reg);
        end
        bus.req = 4'b0110;
        bus.hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (bus.grant !== 4'b0 || bus.write_enable !== 1'b0 || bus.write_reg !== 5'd2 || bus.write_data !== 32'hA1) begin
                bad++;
                $display("FAIL hold cycle %0d: got g=%b we=%b reg=%0d data=%h want g=0000 we=0 reg=2 data=a1", c, bus.grant, bus.write_enable, bus.write_reg, bus.write_data);
            end
        end
        bus.hold = 1'b0;
        step();
        total++;
        if (bus.grant !== 4'b0100 || bus.write_reg !== 5'd3 || bus.write_enable !== 1'b1) begin
            bad++;
            $display("FAIL hold_resume: got g=%b reg=%0d we=%b want g=0100 reg=3 we=1", bus.grant, bus.write_reg, bus.write_enable);
        end
        step();
        total++;
        if (bus.grant !== 4'b0010) begin
            bad++;
            $display("FAIL hold_resume_next: got g=%b want g=0010", bus.grant);
        end
        bus.req = 4'b0000;
    endtask
    task automatic test_reset_mid();
        init_slices();
        bus.req = 4'b0000;
        pulse_reset();
        bus.req = 4'b0100;
        step();
        total++;
        if (bus.grant !== 4'b0100) begin
            bad++;
            $display("FAIL midreset_setup: got g=%b want g=0100", bus.grant);
        end
        reset = 1'b0;
        bus.req = 4'b0110;
        step();
        total++;
        if (bus.grant !== 4'b0 || bus.write_enable !== 1'b0 || bus.write_reg !== 5'd0 || bus.write_data !== 32'd0) begin
            bad++;
            $display("FAIL midreset_clear: got g=%b we=%b reg=%0d data=%h want all zero", bus.grant, bus.write_enable, bus.write_reg, bus.write_data);
        end
        reset = 1'b1;
        step();
        total++;
        if (bus.grant !== 4'b0010 || bus.write_reg !== 5'd2) begin
            bad++;
            $display("FAIL midreset_lowest: got g=%b reg=%0d want g=0010 reg=2", bus.grant, bus.write_reg);
        end
        bus.req = 4'b0000;
    endtask
    task automatic test_back_to_back();
        logic [3:0] eg;
        init_slices();
        bus.req = 4'b0000;
        pulse_reset();
        bus.req = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            step();
            eg = (c % 2 == 0) ? 4'b0001 : 4'b1000;
            total++;
            if (bus.grant !== eg || bus.write_reg !== ((c % 2 == 0) ? 5'd1 : 5'd4)) begin
                bad++;
                $display("FAIL back_to_back cycle %0d: got g=%b reg=%0d want g=%b", c, bus.grant, bus.write_reg, eg);
            end
        end
        bus.req = 4'b0000;
    endtask
    initial begin
        bus.req = 4'b0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.hold = 1'b0;
        test_reset();
        test_round_robin();
        test_mask();
        test_r0_suppress();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
